// File: rtl/vout_pkg.sv
// rtl/vout_pkg.sv - shared state encoding and DAC levels for the video-out line generator
package vout_pkg;

  typedef enum logic [1:0] {SYNC, PORCH, PAYLOAD, BLANK} vout_state_t;

  localparam logic [7:0] LEVEL_SYNC  = 8'h00;
  localparam logic [7:0] LEVEL_BLANK = 8'h20;
  localparam logic [7:0] LEVEL_BASE  = 8'h40;
  localparam logic [7:0] LEVEL_STEP  = 8'd12;

  localparam int FIFO_USED_W = 11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vout_level_map.sv
// rtl/vout_level_map.sv - maps a 4-bit tape symbol to its 8-bit DAC level
module vout_level_map
  import vout_pkg::*;
(
  input  logic [3:0] symbol,
  output logic [7:0] level
);

  // Max is 0x40 + 12*15 = 0xF4, so the 8-bit sum never wraps.
  assign level = LEVEL_BASE + LEVEL_STEP * {4'h0, symbol};

endmodule

// File: rtl/vout_line_gen.sv
// rtl/vout_line_gen.sv - sync/porch/payload line sequencer draining the video-out FIFO
module vout_line_gen
  import vout_pkg::*;
#(
  parameter int SYMBOLS_PER_LINE   = 256,
  parameter int SAMPLES_PER_SYMBOL = 4,
  parameter int SYNC_LEN           = 64,
  parameter int PORCH_LEN          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_clock,
  output logic                   fifo_rd_request,
  input  logic [3:0]             fifo_rd_data,
  input  logic [FIFO_USED_W-1:0] fifo_rd_used_words,
  output logic [7:0]             dac_data,
  output logic                   dac_sync,
  output logic                   line_active,
  output logic [15:0]            underrun_count
);

  localparam int PAY_LEN = SYMBOLS_PER_LINE * SAMPLES_PER_SYMBOL;
  localparam int MAX_LEN = max3(SYNC_LEN, PORCH_LEN, PAY_LEN);
  localparam int PH_W    = $clog2(MAX_LEN);
  localparam int SAMP_W  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int SYM_W   = $clog2(SYMBOLS_PER_LINE + 1);

  localparam logic [PH_W-1:0]        SYNC_LAST  = PH_W'(SYNC_LEN - 1);
  localparam logic [PH_W-1:0]        PORCH_LAST = PH_W'(PORCH_LEN - 1);
  localparam logic [PH_W-1:0]        PAY_LAST   = PH_W'(PAY_LEN - 1);
  localparam logic [SAMP_W-1:0]      SAMP_LAST  = SAMP_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [SYM_W-1:0]       SYM_LAST   = SYM_W'(SYMBOLS_PER_LINE - 1);
  localparam logic [FIFO_USED_W-1:0] FILL_NEED  = FIFO_USED_W'(SYMBOLS_PER_LINE);

  vout_state_t       state, state_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic [SAMP_W-1:0] samp, samp_n;
  logic [SYM_W-1:0]  sym, sym_n;
  logic [3:0]        sym_reg;
  logic [3:0]        cur_sym;
  logic [7:0]        sym_level;
  logic              line_ok;
  logic              decide_n;
  logic              used_ok;
  logic              rd_req_n;
  logic [15:0]       ur_cnt;

  assign fifo_rd_clock  = clk;
  assign underrun_count = ur_cnt;

  // On a symbol's first sample the word is still on the FIFO q; later samples use the held copy.
  assign cur_sym = (samp == '0) ? fifo_rd_data : sym_reg;

  vout_level_map u_level_map (
    .symbol (cur_sym),
    .level  (sym_level)
  );

  always_comb begin
    state_n = state;
    phase_n = phase + 1'b1;
    samp_n  = samp;
    sym_n   = sym;
    case (state)
      SYNC: begin
        if (phase == SYNC_LAST) begin
          state_n = PORCH;
          phase_n = '0;
        end
      end
      PORCH: begin
        if (phase == PORCH_LAST) begin
          state_n = line_ok ? PAYLOAD : BLANK;
          phase_n = '0;
          samp_n  = '0;
          sym_n   = '0;
        end
      end
      PAYLOAD: begin
        if (samp == SAMP_LAST) begin
          samp_n = '0;
          sym_n  = sym + 1'b1;
        end else begin
          samp_n = samp + 1'b1;
        end
        if (phase == PAY_LAST) begin
          state_n = SYNC;
          phase_n = '0;
        end
      end
      BLANK: begin
        if (phase == PAY_LAST) begin
          state_n = SYNC;
          phase_n = '0;
        end
      end
      default: begin
        state_n = SYNC;
        phase_n = '0;
      end
    endcase

    // Fill level is sampled on the edge entering the decision clock, so the strobe can be registered.
    decide_n = (state_n == PORCH) && (phase_n == PORCH_LAST);
    used_ok  = (fifo_rd_used_words >= FILL_NEED);
    rd_req_n = (decide_n && used_ok) ||
               ((state_n == PAYLOAD) && (samp_n == SAMP_LAST) && (sym_n != SYM_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= SYNC;
      phase           <= '0;
      samp            <= '0;
      sym             <= '0;
      sym_reg         <= '0;
      line_ok         <= 1'b0;
      fifo_rd_request <= 1'b0;
      dac_data        <= LEVEL_SYNC;
      dac_sync        <= 1'b0;
      line_active     <= 1'b0;
      ur_cnt          <= '0;
    end else begin
      state           <= state_n;
      phase           <= phase_n;
      samp            <= samp_n;
      sym             <= sym_n;
      fifo_rd_request <= rd_req_n;
      if (decide_n) begin
        line_ok <= used_ok;
      end
      if ((state == PORCH) && (phase == PORCH_LAST) && !line_ok && (ur_cnt != 16'hFFFF)) begin
        ur_cnt <= ur_cnt + 16'd1;
      end
      if ((state == PAYLOAD) && (samp == '0)) begin
        sym_reg <= fifo_rd_data;
      end
      case (state)
        SYNC:    dac_data <= LEVEL_SYNC;
        PAYLOAD: dac_data <= sym_level;
        default: dac_data <= LEVEL_BLANK;
      endcase
      dac_sync    <= (state == SYNC);
      line_active <= (state == PAYLOAD);
    end
  end

endmodule

// File: tb/tb_vout_line_gen.sv
// tb/tb_vout_line_gen.sv - directed self-checking bench for vout_line_gen (13-clock lines)
module tb_vout_line_gen;

  logic        clk;
  logic        rst;
  logic        fifo_rd_clock;
  logic        fifo_rd_request;
  logic [3:0]  fifo_rd_data;
  logic [10:0] fifo_rd_used_words;
  logic [7:0]  dac_data;
  logic        dac_sync;
  logic        line_active;
  logic [15:0] underrun_count;

  logic [3:0]  q[$];
  int          checks;
  int          errors;
  int          rd_cnt;

  vout_line_gen #(
    .SYMBOLS_PER_LINE   (4),
    .SAMPLES_PER_SYMBOL (2),
    .SYNC_LEN           (3),
    .PORCH_LEN          (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_rd_clock      (fifo_rd_clock),
    .fifo_rd_request    (fifo_rd_request),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_used_words (fifo_rd_used_words),
    .dac_data           (dac_data),
    .dac_sync           (dac_sync),
    .line_active        (line_active),
    .underrun_count     (underrun_count)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of a non-showahead FIFO: a strobe seen this cycle delivers a word after the edge.
  task automatic step();
    logic req;
    req = fifo_rd_request;
    @(posedge clk);
    #1;
    if (req === 1'b1) begin
      rd_cnt++;
      if (q.size() > 0) fifo_rd_data = q.pop_front();
    end
    fifo_rd_used_words = 11'(q.size());
  endtask

  task automatic run_line(input string name, input logic [7:0] l0, input logic [7:0] l1,
                          input logic [7:0] l2, input logic [7:0] l3, input bit data,
                          input int n, input int push_at, input logic [3:0] push_val);
    logic [7:0] lv[4];
    logic [7:0] exp_dac;
    lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
    rd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i < 3)      exp_dac = 8'h00;
      else if (i < 5) exp_dac = 8'h20;
      else            exp_dac = lv[(i - 5) / 2];
      chk($sformatf("%s dac[%0d]", name, i), 32'(dac_data), 32'(exp_dac));
      chk($sformatf("%s sync[%0d]", name, i), 32'(dac_sync), 32'(i < 3));
      chk($sformatf("%s active[%0d]", name, i), 32'(line_active), 32'(data && i >= 5));
      chk($sformatf("%s rdreq[%0d]", name, i), 32'(fifo_rd_request),
          32'(data && (i == 3 || i == 5 || i == 7 || i == 9)));
      if (i + 1 == push_at) begin
        q.push_back(push_val);
        fifo_rd_used_words = 11'(q.size());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_cnt = 0;
    rst = 1'b0;
    fifo_rd_data = 4'h0;
    fifo_rd_used_words = 11'd0;

    // Reset held with garbage on the FIFO inputs
    for (int i = 0; i < 5; i++) begin
      fifo_rd_data = 4'($urandom);
      fifo_rd_used_words = 11'($urandom);
      step();
      fifo_rd_data = 4'($urandom);
      fifo_rd_used_words = 11'($urandom);
      chk($sformatf("rst dac[%0d]", i), 32'(dac_data), 32'h00);
      chk($sformatf("rst sync[%0d]", i), 32'(dac_sync), 32'h0);
      chk($sformatf("rst active[%0d]", i), 32'(line_active), 32'h0);
      chk($sformatf("rst rdreq[%0d]", i), 32'(fifo_rd_request), 32'h0);
      chk($sformatf("rst urun[%0d]", i), 32'(underrun_count), 32'h0);
    end
    chk("rst reads", 32'(rd_cnt), 32'd0);

    // Data line: 1,2,3,F -> 4C,58,64,F4
    q = {4'h1, 4'h2, 4'h3, 4'hF};
    fifo_rd_data = 4'h0;
    fifo_rd_used_words = 11'(q.size());
    rst = 1'b1;
    run_line("data1", 8'h4C, 8'h58, 8'h64, 8'hF4, 1'b1, 13, 0, 4'h0);
    chk("data1 reads", 32'(rd_cnt), 32'd4);
    chk("data1 urun", 32'(underrun_count), 32'd0);

    // Underrun: only 3 words buffered
    q = {4'hA, 4'hB, 4'hC};
    fifo_rd_used_words = 11'(q.size());
    run_line("urun", 8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 13, 0, 4'h0);
    chk("urun reads", 32'(rd_cnt), 32'd0);
    chk("urun count", 32'(underrun_count), 32'd1);

    // Fill reaches 4 only on the decision clock: still blank
    run_line("bound", 8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 13, 4, 4'hD);
    chk("bound reads", 32'(rd_cnt), 32'd0);
    chk("bound count", 32'(underrun_count), 32'd2);

    // Next line sees used=4: A,B,C,D -> B8,C4,D0,DC
    run_line("data2", 8'hB8, 8'hC4, 8'hD0, 8'hDC, 1'b1, 13, 0, 4'h0);
    chk("data2 reads", 32'(rd_cnt), 32'd4);
    chk("data2 count", 32'(underrun_count), 32'd2);

    // Saturation at FFFF
    force dut.ur_cnt = 16'hFFFF;
    #1;
    release dut.ur_cnt;
    run_line("sat", 8'h20, 8'h20, 8'h20, 8'h20, 1'b0, 13, 0, 4'h0);
    chk("sat count", 32'(underrun_count), 32'hFFFF);
    chk("sat reads", 32'(rd_cnt), 32'd0);

    // Reset during symbol 2: words 0,4,8 consumed, 9,5,6,7 follow
    q = {4'h0, 4'h4, 4'h8, 4'h9, 4'h5, 4'h6, 4'h7, 4'hE};
    fifo_rd_used_words = 11'(q.size());
    run_line("mid", 8'h40, 8'h70, 8'hA0, 8'hAC, 1'b1, 9, 0, 4'h0);
    rst = 1'b0;
    step();
    chk("midrst dac", 32'(dac_data), 32'h00);
    chk("midrst sync", 32'(dac_sync), 32'h0);
    chk("midrst active", 32'(line_active), 32'h0);
    chk("midrst rdreq", 32'(fifo_rd_request), 32'h0);
    chk("midrst urun", 32'(underrun_count), 32'h0);
    chk("midrst left", 32'(q.size()), 32'd5);
    rst = 1'b1;
    run_line("after", 8'hAC, 8'h7C, 8'h88, 8'h94, 1'b1, 13, 0, 4'h0);
    chk("after reads", 32'(rd_cnt), 32'd4);
    chk("after left", 32'(q.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
